// File: rtl/alu_issue_queue.sv
// ALU reservation station: collapsing queue of dispatched ops with CDB operand wakeup
// and oldest-ready selection toward the ALU.
module alu_issue_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [DATA_W-1:0]            disp_src_1,
  input  logic [DATA_W-1:0]            disp_src_2,
  input  logic                         disp_src_1_rdy,
  input  logic                         disp_src_2_rdy,
  input  logic [TAG_W-1:0]             disp_src_1_tag,
  input  logic [TAG_W-1:0]             disp_src_2_tag,
  input  logic                         disp_dst_valid,
  input  logic [TAG_W-1:0]             disp_dst_tag,
  input  logic [2:0]                   disp_alu_ctrl,
  input  logic                         disp_funct7,
  input  logic                         disp_pred,
  input  logic [31:0]                  disp_target,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [DATA_W-1:0]            cdb_data,
  output logic                         iss_valid,
  input  logic                         iss_ready,
  output logic [DATA_W-1:0]            iss_src_1,
  output logic [DATA_W-1:0]            iss_src_2,
  output logic                         iss_dst_valid,
  output logic [TAG_W-1:0]             iss_dst_tag,
  output logic [2:0]                   iss_alu_ctrl,
  output logic                         iss_funct7,
  output logic                         iss_pred,
  output logic [31:0]                  iss_target,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] src_1;
    logic              src_1_rdy;
    logic [TAG_W-1:0]  src_1_tag;
    logic [DATA_W-1:0] src_2;
    logic              src_2_rdy;
    logic [TAG_W-1:0]  src_2_tag;
    logic              dst_valid;
    logic [TAG_W-1:0]  dst_tag;
    logic [2:0]        alu_ctrl;
    logic              funct7;
    logic              pred;
    logic [31:0]       target;
  } entry_t;

  entry_t             r_q     [DEPTH];
  logic [CNT_W-1:0]   r_count;

  entry_t             w_woke  [DEPTH];
  entry_t             w_q_nxt [DEPTH];
  entry_t             w_disp_e;
  logic [DEPTH-1:0]   w_valid;
  logic               w_sel_found;
  logic [IDX_W-1:0]   w_sel_idx;
  logic               w_issue;
  logic               w_disp;
  logic [CNT_W-1:0]   w_wr_idx;
  logic [CNT_W-1:0]   w_count_nxt;

  // Capture a CDB broadcast into any not-yet-ready source of one entry.
  function automatic entry_t wake(input entry_t e, input logic v,
                                  input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    wake = e;
    if (v && !e.src_1_rdy && (e.src_1_tag == t)) begin
      wake.src_1     = d;
      wake.src_1_rdy = 1'b1;
    end
    if (v && !e.src_2_rdy && (e.src_2_tag == t)) begin
      wake.src_2     = d;
      wake.src_2_rdy = 1'b1;
    end
  endfunction

  // Oldest valid entry with both operands ready.
  always_comb begin
    w_valid     = '0;
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_valid[i] = (CNT_W'(i) < r_count);
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_valid[i] && r_q[i].src_1_rdy && r_q[i].src_2_rdy) begin
        w_sel_found = 1'b1;
        w_sel_idx   = IDX_W'(i);
      end
    end
  end

  assign disp_ready = (r_count < CNT_W'(DEPTH));
  assign w_issue    = w_sel_found && iss_ready && !flush;
  assign w_disp     = disp_valid && disp_ready && !flush;
  assign w_wr_idx   = r_count - CNT_W'(w_issue);

  always_comb begin
    w_disp_e           = '0;
    w_disp_e.src_1     = disp_src_1;
    w_disp_e.src_1_rdy = disp_src_1_rdy;
    w_disp_e.src_1_tag = disp_src_1_tag;
    w_disp_e.src_2     = disp_src_2;
    w_disp_e.src_2_rdy = disp_src_2_rdy;
    w_disp_e.src_2_tag = disp_src_2_tag;
    w_disp_e.dst_valid = disp_dst_valid;
    w_disp_e.dst_tag   = disp_dst_tag;
    w_disp_e.alu_ctrl  = disp_alu_ctrl;
    w_disp_e.funct7    = disp_funct7;
    w_disp_e.pred      = disp_pred;
    w_disp_e.target    = disp_target;
    w_disp_e           = wake(w_disp_e, cdb_valid, cdb_tag, cdb_data);
  end

  // Next queue contents: wakeup, collapse over the issued slot, then append dispatch.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_woke[i]  = w_valid[i] ? wake(r_q[i], cdb_valid, cdb_tag, cdb_data) : r_q[i];
      w_q_nxt[i] = w_woke[i];
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (w_issue && (IDX_W'(i) >= w_sel_idx)) begin
        w_q_nxt[i] = w_woke[i+1];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (w_disp && (CNT_W'(i) == w_wr_idx)) begin
        w_q_nxt[i] = w_disp_e;
      end
    end
    if (flush) begin
      w_count_nxt = '0;
    end else begin
      w_count_nxt = r_count + CNT_W'(w_disp) - CNT_W'(w_issue);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      r_count <= w_count_nxt;
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i] <= w_q_nxt[i];
      end
    end
  end

  // Payload is zeroed whenever nothing is issuable.
  always_comb begin
    iss_valid     = w_sel_found;
    iss_src_1     = '0;
    iss_src_2     = '0;
    iss_dst_valid = 1'b0;
    iss_dst_tag   = '0;
    iss_alu_ctrl  = '0;
    iss_funct7    = 1'b0;
    iss_pred      = 1'b0;
    iss_target    = '0;
    if (w_sel_found) begin
      iss_src_1     = r_q[w_sel_idx].src_1;
      iss_src_2     = r_q[w_sel_idx].src_2;
      iss_dst_valid = r_q[w_sel_idx].dst_valid;
      iss_dst_tag   = r_q[w_sel_idx].dst_tag;
      iss_alu_ctrl  = r_q[w_sel_idx].alu_ctrl;
      iss_funct7    = r_q[w_sel_idx].funct7;
      iss_pred      = r_q[w_sel_idx].pred;
      iss_target    = r_q[w_sel_idx].target;
    end
  end

  assign count = r_count;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed self-checking bench for alu_issue_queue (DEPTH=4, TAG_W=4, DATA_W=32).
module tb_alu_issue_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        disp_valid;
  logic        disp_ready;
  logic [31:0] disp_src_1, disp_src_2;
  logic        disp_src_1_rdy, disp_src_2_rdy;
  logic [3:0]  disp_src_1_tag, disp_src_2_tag;
  logic        disp_dst_valid;
  logic [3:0]  disp_dst_tag;
  logic [2:0]  disp_alu_ctrl;
  logic        disp_funct7;
  logic        disp_pred;
  logic [31:0] disp_target;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        iss_valid;
  logic        iss_ready;
  logic [31:0] iss_src_1, iss_src_2;
  logic        iss_dst_valid;
  logic [3:0]  iss_dst_tag;
  logic [2:0]  iss_alu_ctrl;
  logic        iss_funct7;
  logic        iss_pred;
  logic [31:0] iss_target;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  alu_issue_queue #(.DEPTH(4), .TAG_W(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_src_1(disp_src_1), .disp_src_2(disp_src_2),
    .disp_src_1_rdy(disp_src_1_rdy), .disp_src_2_rdy(disp_src_2_rdy),
    .disp_src_1_tag(disp_src_1_tag), .disp_src_2_tag(disp_src_2_tag),
    .disp_dst_valid(disp_dst_valid), .disp_dst_tag(disp_dst_tag),
    .disp_alu_ctrl(disp_alu_ctrl), .disp_funct7(disp_funct7),
    .disp_pred(disp_pred), .disp_target(disp_target),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_src_1(iss_src_1), .iss_src_2(iss_src_2),
    .iss_dst_valid(iss_dst_valid), .iss_dst_tag(iss_dst_tag),
    .iss_alu_ctrl(iss_alu_ctrl), .iss_funct7(iss_funct7),
    .iss_pred(iss_pred), .iss_target(iss_target),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task step();
    @(posedge clk);
    #1;
  endtask

  task set_disp(input logic [31:0] a, input logic ra, input logic [3:0] ta,
                input logic [31:0] b, input logic rb, input logic [3:0] tb2,
                input logic [3:0] dst);
    disp_valid     = 1'b1;
    disp_src_1     = a;
    disp_src_1_rdy = ra;
    disp_src_1_tag = ta;
    disp_src_2     = b;
    disp_src_2_rdy = rb;
    disp_src_2_tag = tb2;
    disp_dst_valid = 1'b1;
    disp_dst_tag   = dst;
    disp_alu_ctrl  = 3'd0;
    disp_funct7    = 1'b0;
    disp_pred      = 1'b0;
    disp_target    = 32'h0;
  endtask

  task idle();
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
    flush      = 1'b0;
    iss_ready  = 1'b0;
  endtask

  task test_reset();
    idle();
    set_disp(32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0);
    disp_valid = 1'b0;
    cdb_tag = 4'h0; cdb_data = 32'h0;
    rst = 1'b0;
    #12;
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count got %0d exp 0", count); end
    n_cmp++; if (iss_valid !== 1'b0) begin n_bad++; $display("FAIL reset_iss_valid got %0b exp 0", iss_valid); end
    n_cmp++; if (iss_src_1 !== 32'h0) begin n_bad++; $display("FAIL reset_iss_src_1 got %0h exp 0", iss_src_1); end
    @(negedge clk);
    rst = 1'b1;
    step();
    n_cmp++; if (disp_ready !== 1'b1) begin n_bad++; $display("FAIL reset_disp_ready got %0b exp 1", disp_ready); end
  endtask

  task test_basic_issue();
    set_disp(32'd5, 1'b1, 4'h0, 32'd7, 1'b1, 4'h0, 4'd3);
    iss_ready = 1'b1;
    n_cmp++; if (iss_valid !== 1'b0) begin n_bad++; $display("FAIL basic_no_bypass got %0b exp 0", iss_valid); end
    step();
    disp_valid = 1'b0;
    n_cmp++; if (iss_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got %0b exp 1", iss_valid); end
    n_cmp++; if (iss_src_1 !== 32'd5) begin n_bad++; $display("FAIL basic_src_1 got %0h exp 5", iss_src_1); end
    n_cmp++; if (iss_src_2 !== 32'd7) begin n_bad++; $display("FAIL basic_src_2 got %0h exp 7", iss_src_2); end
    n_cmp++; if (iss_dst_tag !== 4'd3) begin n_bad++; $display("FAIL basic_dst_tag got %0h exp 3", iss_dst_tag); end
    n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL basic_count1 got %0d exp 1", count); end
    step();
    iss_ready = 1'b0;
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL basic_count0 got %0d exp 0", count); end
    n_cmp++; if (iss_valid !== 1'b0) begin n_bad++; $display("FAIL basic_empty got %0b exp 0", iss_valid); end
  endtask

  task test_cdb_wakeup();
    set_disp(32'd1, 1'b1, 4'h0, 32'hDEAD, 1'b0, 4'd9, 4'd1);
    step();
    set_disp(32'd2, 1'b1, 4'h0, 32'd3, 1'b1, 4'h0, 4'd2);
    step();
    disp_valid = 1'b0;
    n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL wake_count got %0d exp 2", count); end
    n_cmp++; if (iss_dst_tag !== 4'd2) begin n_bad++; $display("FAIL wake_b_first got %0h exp 2", iss_dst_tag); end
    iss_ready = 1'b1;
    step();
    iss_ready = 1'b0;
    n_cmp++; if (iss_valid !== 1'b0) begin n_bad++; $display("FAIL wake_a_waiting got %0b exp 0", iss_valid); end
    cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 32'h1234;
    step();
    cdb_valid = 1'b0;
    n_cmp++; if (iss_valid !== 1'b1) begin n_bad++; $display("FAIL wake_a_valid got %0b exp 1", iss_valid); end
    n_cmp++; if (iss_src_2 !== 32'h1234) begin n_bad++; $display("FAIL wake_a_src_2 got %0h exp 1234", iss_src_2); end
    n_cmp++; if (iss_dst_tag !== 4'd1) begin n_bad++; $display("FAIL wake_a_dst got %0h exp 1", iss_dst_tag); end
    iss_ready = 1'b1;
    step();
    iss_ready = 1'b0;
    // both sources waiting on the same producer
    set_disp(32'h0, 1'b0, 4'd7, 32'h0, 1'b0, 4'd7, 4'd4);
    step();
    disp_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_data = 32'h55;
    step();
    cdb_valid = 1'b0;
    n_cmp++; if (iss_src_1 !== 32'h55) begin n_bad++; $display("FAIL wake_both_src_1 got %0h exp 55", iss_src_1); end
    n_cmp++; if (iss_src_2 !== 32'h55) begin n_bad++; $display("FAIL wake_both_src_2 got %0h exp 55", iss_src_2); end
    iss_ready = 1'b1;
    step();
    iss_ready = 1'b0;
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL wake_drain got %0d exp 0", count); end
  endtask

  task test_disp_wakeup();
    set_disp(32'hFFFF, 1'b0, 4'd6, 32'd4, 1'b1, 4'd6, 4'd5);
    disp_alu_ctrl = 3'b101; disp_funct7 = 1'b1; disp_pred = 1'b1; disp_target = 32'h1000;
    cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_data = 32'hAA;
    step();
    disp_valid = 1'b0; cdb_valid = 1'b0;
    n_cmp++; if (iss_valid !== 1'b1) begin n_bad++; $display("FAIL dwake_valid got %0b exp 1", iss_valid); end
    n_cmp++; if (iss_src_1 !== 32'hAA) begin n_bad++; $display("FAIL dwake_src_1 got %0h exp aa", iss_src_1); end
    n_cmp++; if (iss_src_2 !== 32'd4) begin n_bad++; $display("FAIL dwake_rdy_src_2 got %0h exp 4", iss_src_2); end
    n_cmp++; if ({iss_alu_ctrl, iss_funct7, iss_pred} !== 5'b10111) begin n_bad++; $display("FAIL dwake_ctrl got %0b exp 10111", {iss_alu_ctrl, iss_funct7, iss_pred}); end
    n_cmp++; if (iss_target !== 32'h1000) begin n_bad++; $display("FAIL dwake_target got %0h exp 1000", iss_target); end
    iss_ready = 1'b1;
    step();
    iss_ready = 1'b0;
  endtask

  task test_full();
    for (int k = 0; k < 4; k++) begin
      set_disp(32'(k), 1'b1, 4'h0, 32'(k), 1'b1, 4'h0, 4'(10 + k));
      step();
    end
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL full_count got %0d exp 4", count); end
    n_cmp++; if (disp_ready !== 1'b0) begin n_bad++; $display("FAIL full_disp_ready got %0b exp 0", disp_ready); end
    set_disp(32'd99, 1'b1, 4'h0, 32'd99, 1'b1, 4'h0, 4'd14);
    step();
    disp_valid = 1'b0;
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL full_ignored got %0d exp 4", count); end
    n_cmp++; if (iss_dst_tag !== 4'd10) begin n_bad++; $display("FAIL full_head got %0h exp a", iss_dst_tag); end
    iss_ready = 1'b1;
    step();
    iss_ready = 1'b0;
    n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL full_after_issue got %0d exp 3", count); end
    n_cmp++; if (disp_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready_again got %0b exp 1", disp_ready); end
    iss_ready = 1'b1;
    for (int k = 11; k < 14; k++) begin
      n_cmp++; if (iss_dst_tag !== 4'(k)) begin n_bad++; $display("FAIL full_order got %0h exp %0h", iss_dst_tag, k); end
      step();
    end
    iss_ready = 1'b0;
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL full_drained got %0d exp 0", count); end
  endtask

  task test_back_to_back();
    set_disp(32'd1, 1'b1, 4'h0, 32'd1, 1'b1, 4'h0, 4'd1);
    step();
    set_disp(32'd2, 1'b1, 4'h0, 32'd2, 1'b1, 4'h0, 4'd2);
    step();
    set_disp(32'd3, 1'b1, 4'h0, 32'd3, 1'b1, 4'h0, 4'd3);
    iss_ready = 1'b1;
    step();
    disp_valid = 1'b0; iss_ready = 1'b0;
    n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL b2b_count got %0d exp 2", count); end
    n_cmp++; if (iss_dst_tag !== 4'd2) begin n_bad++; $display("FAIL b2b_older got %0h exp 2", iss_dst_tag); end
    iss_ready = 1'b1;
    step();
    n_cmp++; if (iss_dst_tag !== 4'd3) begin n_bad++; $display("FAIL b2b_newer got %0h exp 3", iss_dst_tag); end
    step();
    iss_ready = 1'b0;
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL b2b_drained got %0d exp 0", count); end
  endtask

  task test_flush();
    for (int k = 0; k < 3; k++) begin
      set_disp(32'(k), 1'b1, 4'h0, 32'(k), 1'b1, 4'h0, 4'(k + 1));
      step();
    end
    set_disp(32'd8, 1'b1, 4'h0, 32'd8, 1'b1, 4'h0, 4'd8);
    flush = 1'b1; iss_ready = 1'b1;
    step();
    idle();
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL flush_count got %0d exp 0", count); end
    n_cmp++; if (iss_valid !== 1'b0) begin n_bad++; $display("FAIL flush_iss_valid got %0b exp 0", iss_valid); end
    n_cmp++; if (iss_dst_tag !== 4'd0) begin n_bad++; $display("FAIL flush_payload got %0h exp 0", iss_dst_tag); end
  endtask

  task test_async_reset();
    set_disp(32'h77, 1'b1, 4'h0, 32'h66, 1'b1, 4'h0, 4'd6);
    step();
    step();
    disp_valid = 1'b0;
    n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL arst_pre_count got %0d exp 2", count); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL arst_count got %0d exp 0", count); end
    n_cmp++; if (iss_valid !== 1'b0) begin n_bad++; $display("FAIL arst_iss_valid got %0b exp 0", iss_valid); end
    n_cmp++; if (iss_src_1 !== 32'h0) begin n_bad++; $display("FAIL arst_src_1 got %0h exp 0", iss_src_1); end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_basic_issue();
    test_cdb_wakeup();
    test_disp_wakeup();
    test_full();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Reservation station feeding the execute-stage ALU of the out-of-order core.
- Holds up to DEPTH dispatched ALU ops.
- Captures operand values from dispatch, or later from the common data bus (CDB) by tag match.
- Issues the oldest entry with both operands ready on a valid/ready handshake to the ALU.

Parameters:
DEPTH, 4, number of entries (2..8)
TAG_W, 4, physical destination/source tag width
DATA_W, 32, operand width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (asserted at 0)
flush  in  1  synchronous squash of all entries (mispredict recovery)
disp_valid  in  1  dispatch request
disp_ready  out  1  queue can accept an entry this cycle
disp_src_1 / disp_src_2  in  DATA_W  operand values, meaningful when the matching rdy bit is 1
disp_src_1_rdy / disp_src_2_rdy  in  1  operand already available
disp_src_1_tag / disp_src_2_tag  in  TAG_W  producer tag when not ready
disp_dst_valid  in  1  op writes a destination
disp_dst_tag  in  TAG_W  destination tag
disp_alu_ctrl  in  3  funct3 ALU select
disp_funct7  in  1  funct7[5] (SUB/SRA)
disp_pred  in  1  branch prediction bit
disp_target  in  32  predicted target
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  broadcast tag
cdb_data  in  DATA_W  broadcast value
iss_valid  out  1  an entry is issuable
iss_ready  in  1  ALU accepts (ALU enable)
iss_src_1 / iss_src_2 / iss_dst_valid / iss_dst_tag / iss_alu_ctrl / iss_funct7 / iss_pred / iss_target  out  as dispatch  selected entry payload
count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Storage is a collapsing queue. Entry 0 is the oldest; valid entries are contiguous from index 0.
- Reset (rst=0, async):
  - All entry valid bits cleared; count=0.
  - iss_valid=0 and all iss_* payload outputs 0. Payload outputs are forced to 0 whenever iss_valid=0.
  - disp_ready=1 once rst releases.
- disp_ready = (count < DEPTH). It is combinational and does not credit a same-cycle issue.
- Dispatch fires when disp_valid && disp_ready && !flush.
  - Entry is written at index count, or count-1 if an issue fires in the same cycle.
- Same-cycle wakeup at dispatch: if a src has rdy=0, cdb_valid=1 and cdb_tag equals that src tag, the entry stores cdb_data with rdy=1.
- Wakeup of stored entries: every cycle, for each valid entry and each not-ready src with a matching tag while cdb_valid, capture cdb_data and set rdy.
  - Both srcs of one entry may wake on the same broadcast.
  - Ready srcs ignore the CDB.
- Select (combinational from registered state):
  - iss_valid=1 iff some valid entry has both srcs ready.
  - Selected entry is the lowest such index.
  - Payload is that entry's fields.
  - The selection may change while iss_valid && !iss_ready; the ALU samples only on the handshake.
- Issue fires when iss_valid && iss_ready && !flush. At the edge the selected entry is removed, entries above it shift down one index, and count decrements.
- Latency:
  - Dispatch with both srcs ready at edge N gives iss_valid in cycle N+1 (assuming no older ready entry).
  - CDB wakeup at edge N makes the entry issuable in cycle N+1.
  - Minimum dispatch-to-issue is 1 cycle; there is no bypass to the same cycle.
- Simultaneous dispatch and issue: count unchanged, and the new entry lands after the collapse.
- Full queue: disp_ready=0. A dispatch attempt is ignored and state is unchanged.
- Empty queue: iss_valid=0 and iss_ready is ignored.
- flush:
  - Highest synchronous priority: clears all valid bits and sets count=0 at the edge.
  - A same-cycle dispatch is dropped; a same-cycle issue handshake is void (the ALU must also squash).
- Asserting rst mid-operation clears state immediately regardless of clk.
- Tags are never compared for entries with valid=0.

Test Plan:
- Reset, then dispatch add with src_1=5 (rdy), src_2=7 (rdy), dst_tag=3, iss_ready=1 -> iss_valid=1 next cycle, iss_src_1=5, iss_src_2=7, iss_dst_tag=3; count 1->0 after the handshake.
- Dispatch op A with src_2 tag 9 not ready, then op B fully ready -> B issues first. Then cdb_valid with tag 9 and data 0x1234 -> A issues next cycle with iss_src_2=0x1234.
- Dispatch with src_1 tag 6 not ready while the CDB broadcasts tag 6 with data 0xAA in the same cycle -> entry is issuable the next cycle with iss_src_1=0xAA.
- Fill 4 entries with iss_ready=0 -> disp_ready=0 and count=4; a 5th dispatch is ignored. Release iss_ready for one cycle -> entry 0 is removed, the remaining three keep their order, and disp_ready=1.
- Same-cycle dispatch and issue at count=2 -> count stays 2, and the new entry is issued after the surviving older one.
- With 3 entries, assert flush together with disp_valid -> count=0 and iss_valid=0 next cycle. Pulse rst=0 mid-cycle with entries present -> outputs go to 0 without waiting for a clock edge.
